// File: rtl/popcount_accum.sv
// Streaming masked Hamming-weight accumulator: one total, word count and overflow flag per frame.
// Pipeline: stage 1 registers the popcount, stage 2 carries the word, and the accumulator/result update happens as it leaves stage 2.
module popcount_accum #(
    parameter int DATA_W    = 64,
    parameter int MAX_WORDS = 256,
    parameter int CNT_W     = $clog2(MAX_WORDS*DATA_W+1),
    parameter int WC_W      = $clog2(MAX_WORDS+1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [DATA_W-1:0] s_mask,
    input  logic              s_zeros,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  m_count,
    output logic [WC_W-1:0]   m_words,
    output logic              m_ovf
);

    localparam int PC_W   = $clog2(DATA_W+1);
    localparam int LEAVES = 1 << $clog2(DATA_W);

    // Handshake: a word moves on s_valid & s_ready, a result on m_valid & m_ready;
    // a held result (m_valid & ~m_ready) freezes the whole pipeline and blocks input.
    logic w_hold;
    assign w_hold  = m_valid & ~m_ready;
    assign s_ready = ~w_hold;

    logic [DATA_W-1:0] w_word;
    logic [LEAVES-1:0] w_pad;
    logic [PC_W-1:0]   w_node [2*LEAVES];
    logic [PC_W-1:0]   w_pc;

    // Heap-ordered adder tree: leaves at [LEAVES+i], node k sums children 2k and 2k+1.
    always_comb begin
        w_word = (s_zeros ? ~s_data : s_data) & s_mask;
        w_pad  = LEAVES'(w_word);
        w_node = '{default: '0};
        for (int i = 0; i < LEAVES; i++) begin
            w_node[LEAVES+i] = PC_W'(w_pad[i]);
        end
        for (int k = LEAVES-1; k >= 1; k--) begin
            w_node[k] = w_node[2*k] + w_node[2*k+1];
        end
        w_pc = w_node[1];
    end

    logic            r_s1_valid, r_s1_last;
    logic [PC_W-1:0] r_s1_pc;
    logic            r_s2_valid, r_s2_last;
    logic [PC_W-1:0] r_s2_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_pc    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_pc    <= '0;
        end else if (!w_hold) begin
            r_s1_valid <= s_valid;
            r_s1_last  <= s_last;
            r_s1_pc    <= w_pc;
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
            r_s2_pc    <= r_s1_pc;
        end
    end

    logic [CNT_W-1:0] r_acc;
    logic [WC_W-1:0]  r_wc;
    logic             r_ovf;
    logic [CNT_W-1:0] w_acc_next;
    logic [WC_W-1:0]  w_wc_next;
    logic             w_ovf_next;
    logic             w_full;
    logic             w_take;

    // Once MAX_WORDS words are in, further words only set the overflow flag.
    always_comb begin
        w_full     = (r_wc == WC_W'(MAX_WORDS));
        w_acc_next = w_full ? r_acc : r_acc + CNT_W'(r_s2_pc);
        w_wc_next  = w_full ? r_wc  : r_wc + WC_W'(1);
        w_ovf_next = r_ovf | w_full;
        w_take     = r_s2_valid & ~w_hold;
    end

    logic             r_m_valid;
    logic [CNT_W-1:0] r_m_count;
    logic [WC_W-1:0]  r_m_words;
    logic             r_m_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_wc      <= '0;
            r_ovf     <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_count <= '0;
            r_m_words <= '0;
            r_m_ovf   <= 1'b0;
        end else begin
            if (w_take && r_s2_last) begin
                r_acc     <= '0;
                r_wc      <= '0;
                r_ovf     <= 1'b0;
                r_m_valid <= 1'b1;
                r_m_count <= w_acc_next;
                r_m_words <= w_wc_next;
                r_m_ovf   <= w_ovf_next;
            end else begin
                if (w_take) begin
                    r_acc <= w_acc_next;
                    r_wc  <= w_wc_next;
                    r_ovf <= w_ovf_next;
                end
                if (m_ready) begin
                    r_m_valid <= 1'b0;
                end
            end
        end
    end

    assign m_valid = r_m_valid;
    assign m_count = r_m_count;
    assign m_words = r_m_words;
    assign m_ovf   = r_m_ovf;

endmodule

// File: tb/tb_popcount_accum.sv
// Bench for popcount_accum: directed frames on a 64-bit instance, then a randomized
// 1000-frame stream on a 16-bit instance scored against a queue of expected results.
module tb_popcount_accum;

    localparam int AW  = 64;
    localparam int AM  = 4;
    localparam int ACW = $clog2(AM*AW+1);
    localparam int AWW = $clog2(AM+1);
    localparam int BW  = 16;
    localparam int BM  = 4;
    localparam int BCW = $clog2(BM*BW+1);
    localparam int BWW = $clog2(BM+1);
    localparam int N_FRAMES = 1000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic           a_s_valid, a_s_ready, a_s_zeros, a_s_last;
    logic [AW-1:0]  a_s_data, a_s_mask;
    logic           a_m_valid, a_m_ready, a_m_ovf;
    logic [ACW-1:0] a_m_count;
    logic [AWW-1:0] a_m_words;

    logic           b_s_valid, b_s_ready, b_s_zeros, b_s_last;
    logic [BW-1:0]  b_s_data, b_s_mask;
    logic           b_m_valid, b_m_ready, b_m_ovf;
    logic [BCW-1:0] b_m_count;
    logic [BWW-1:0] b_m_words;

    popcount_accum #(.DATA_W(AW), .MAX_WORDS(AM)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data), .s_mask(a_s_mask),
        .s_zeros(a_s_zeros), .s_last(a_s_last),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_count(a_m_count),
        .m_words(a_m_words), .m_ovf(a_m_ovf)
    );

    popcount_accum #(.DATA_W(BW), .MAX_WORDS(BM)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_mask(b_s_mask),
        .s_zeros(b_s_zeros), .s_last(b_s_last),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_count(b_m_count),
        .m_words(b_m_words), .m_ovf(b_m_ovf)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    logic [BCW+BWW:0] exp_q[$];
    bit b_done = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic a_sync();
        @(posedge clk);
        #1;
    endtask

    // Presents one word from posedge+1 and returns at posedge+1 after it is accepted.
    task automatic a_send(input logic [AW-1:0] d, input logic [AW-1:0] m, input logic z, input logic l);
        bit rdy = 1'b0;
        a_s_data = d; a_s_mask = m; a_s_zeros = z; a_s_last = l; a_s_valid = 1'b1;
        for (int n = 0; n < 200 && !rdy; n++) begin
            @(negedge clk);
            rdy = a_s_ready;
            @(posedge clk);
        end
        #1 a_s_valid = 1'b0;
        if (!rdy) check("a_send_timeout", 64'd0, 64'd1);
    endtask

    task automatic a_wait_result(input int budget, output bit found);
        found = 1'b0;
        for (int n = 0; n < budget && !found; n++) begin
            @(negedge clk);
            if (a_m_valid) found = 1'b1;
        end
    endtask

    task automatic b_send(input logic [BW-1:0] d, input logic [BW-1:0] m, input logic z, input logic l);
        bit rdy = 1'b0;
        b_s_data = d; b_s_mask = m; b_s_zeros = z; b_s_last = l; b_s_valid = 1'b1;
        for (int n = 0; n < 500 && !rdy && !b_done; n++) begin
            @(negedge clk);
            rdy = b_s_ready;
            @(posedge clk);
        end
        #1 b_s_valid = 1'b0;
        if (!rdy) check("b_send_timeout", 64'd0, 64'd1);
    endtask

    localparam logic [AW-1:0] ONES = {AW{1'b1}};

    initial begin
        bit found;
        rst_n = 1'b0;
        a_s_valid = 1'b0; a_s_data = '0; a_s_mask = '0; a_s_zeros = 1'b0; a_s_last = 1'b0; a_m_ready = 1'b1;
        b_s_valid = 1'b0; b_s_data = '0; b_s_mask = '0; b_s_zeros = 1'b0; b_s_last = 1'b0; b_m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_m_valid", a_m_valid, 64'd0);
        check("rst_m_count", a_m_count, 64'd0);
        check("rst_m_words", a_m_words, 64'd0);
        check("rst_m_ovf",   a_m_ovf,   64'd0);
        check("rst_s_ready", a_s_ready, 64'd1);
        check("rst_b_out", {b_m_valid, b_m_count, b_m_words, b_m_ovf, b_s_ready}, 64'd1);

        // Three-word frame with exact latency tracking.
        a_sync();
        a_send(ONES, ONES, 1'b0, 1'b0);
        a_send(64'h1, ONES, 1'b0, 1'b0);
        a_send(64'h0, ONES, 1'b0, 1'b1);
        @(negedge clk); check("t1_lat_edge_t",  a_m_valid, 64'd0);
        @(negedge clk); check("t1_lat_edge_t1", a_m_valid, 64'd0);
        @(negedge clk); check("t1_lat_edge_t2", a_m_valid, 64'd1);
        check("t1_count", a_m_count, 64'd65);
        check("t1_words", a_m_words, 64'd3);
        check("t1_ovf",   a_m_ovf,   64'd0);
        @(negedge clk); check("t1_released", a_m_valid, 64'd0);

        // Single word, zeros mode under a partial mask.
        a_sync();
        a_send(64'hF0, 64'hFF, 1'b1, 1'b1);
        a_wait_result(8, found);
        check("t2_found", found, 64'd1);
        check("t2_result", {a_m_count, a_m_words, a_m_ovf}, {9'd4, 3'd1, 1'b0});

        // Six words into a four-word frame limit.
        a_sync();
        for (int i = 0; i < 6; i++) a_send(ONES, ONES, 1'b0, (i == 5));
        a_wait_result(8, found);
        check("t3_found", found, 64'd1);
        check("t3_result", {a_m_count, a_m_words, a_m_ovf}, {9'd256, 3'd4, 1'b1});

        // Back-to-back frames with the first result held by backpressure.
        a_sync();
        a_m_ready = 1'b0;
        a_send(64'hFF, ONES, 1'b0, 1'b0);
        a_send(64'hF,  ONES, 1'b0, 1'b1);
        a_send(64'h1,  ONES, 1'b0, 1'b0);
        a_send(64'h3,  ONES, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_valid", a_m_valid, 64'd1);
            check("t4_hold_ready", a_s_ready, 64'd0);
            check("t4_hold_result", {a_m_count, a_m_words, a_m_ovf}, {9'd12, 3'd2, 1'b0});
        end
        a_m_ready = 1'b1;
        @(negedge clk);
        check("t4_first_taken", a_m_valid, 64'd0);
        a_wait_result(8, found);
        check("t4_second_found", found, 64'd1);
        check("t4_second_result", {a_m_count, a_m_words, a_m_ovf}, {9'd3, 3'd2, 1'b0});

        // Reset in the middle of a frame, then a fresh single-word frame.
        a_sync();
        a_send(ONES, ONES, 1'b0, 1'b0);
        a_send(ONES, ONES, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("t5_rst_valid", a_m_valid, 64'd0);
        check("t5_rst_ready", a_s_ready, 64'd1);
        a_sync();
        a_send(64'h3, ONES, 1'b0, 1'b1);
        a_wait_result(8, found);
        check("t5_found", found, 64'd1);
        check("t5_result", {a_m_count, a_m_words, a_m_ovf}, {9'd2, 3'd1, 1'b0});

        // Randomized stream on the 16-bit instance.
        a_sync();
        fork
            begin : driver
                logic [BW-1:0] wd [6];
                logic [BW-1:0] wm [6];
                logic          wz [6];
                int n, cnt, sel, gap;
                for (int f = 0; f < N_FRAMES && !b_done; f++) begin
                    n = $urandom_range(1, 6);
                    cnt = 0;
                    for (int w = 0; w < n; w++) begin
                        wd[w] = BW'($urandom);
                        sel = $urandom_range(0, 3);
                        wm[w] = (sel == 0) ? {BW{1'b1}} : (sel == 1) ? '0 : BW'($urandom);
                        wz[w] = 1'($urandom_range(0, 1));
                        if (w < BM) cnt += $countones((wz[w] ? ~wd[w] : wd[w]) & wm[w]);
                    end
                    exp_q.push_back({BCW'(cnt), BWW'((n < BM) ? n : BM), (n > BM)});
                    for (int w = 0; w < n; w++) begin
                        gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                        repeat (gap) a_sync();
                        b_send(wd[w], wm[w], wz[w], (w == n-1));
                    end
                end
            end
            begin : backpressure
                while (!b_done) begin
                    a_sync();
                    b_m_ready = ($urandom_range(0, 3) != 0);
                end
                b_m_ready = 1'b1;
            end
            begin : monitor
                int got = 0;
                bit held = 1'b0;
                logic [BCW+BWW:0] held_v = '0;
                logic [BCW+BWW:0] cur;
                for (int c = 0; c < 60000 && got < N_FRAMES; c++) begin
                    @(negedge clk);
                    cur = {b_m_count, b_m_words, b_m_ovf};
                    if (held) begin
                        check("b_hold_stable", {b_m_valid, cur}, {1'b1, held_v});
                    end else if (b_m_valid) begin
                        got++;
                        if (exp_q.size() == 0) check("b_unexpected_result", 64'd0, 64'd1);
                        else check("b_result", cur, exp_q.pop_front());
                    end
                    held = b_m_valid & ~b_m_ready;
                    held_v = cur;
                end
                check("b_frames_seen", got, N_FRAMES);
                check("b_queue_empty", exp_q.size(), 64'd0);
                b_done = 1'b1;
            end
        join

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
